igbt_gate_drive_ctrl: RTL and testbench
=======================================

IGBT_GATE_DRIVE_CTRL -- requirements
Module: igbt_gate_drive_ctrl

Interface
REQ-001 The block SHALL have parameter DEAD_CYC, default 50, meaning the dead-time in sys_clk cycles before any gate turn-on (1 us at 50 MHz).
REQ-002 The block SHALL have parameter MAX_ON_CYC, default 5000000, meaning the maximum continuous gate-on time in cycles (100 ms).
REQ-003 The block SHALL have parameter RST_PULSE_CYC, default 500, meaning the driver-reset pulse width in cycles (10 us).
REQ-004 Port sys_clk, input, 1, meaning the single system clock (50 MHz).
REQ-005 Port sys_rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-006 Port on_en, input, 2, meaning the per-channel IGBT turn-on request from charge logic; bit 0 = channel 1, bit 1 = channel 2.
REQ-007 Port fault_drv, input, 2, meaning the asynchronous active-high driver-board fault per channel.
REQ-008 Port error_drv, input, 2, meaning the asynchronous active-high driver "both inputs high" alarm per channel.
REQ-009 Port clr_fault, input, 1, meaning a single-cycle pulse that acknowledges a latched fault.
REQ-010 Port gate, output, 2, meaning the registered IGBT gate commands.
REQ-011 Port reset_drv, output, 2, meaning the registered driver-board reset pulse, with both bits identical.
REQ-012 Port fault_flag, output, 1, meaning a fault is latched.
REQ-013 Port timeout_flag, output, 2, meaning the per-channel max-on time was exceeded (sticky).
REQ-014 Port conflict_flag, output, 1, meaning both requests were seen together (sticky).

Function
REQ-015 fault_drv and error_drv SHALL each pass through 2-flop synchronizers; flt_s = OR of all four synchronized bits.
REQ-016 The FSM SHALL have the states IDLE, DEAD, ON, HOLD, FAULT, RSTDRV and WAITREL; the target channel tgt SHALL be captured on the IDLE->DEAD transition.
REQ-017 In IDLE, on_en=01 SHALL select tgt=0, and on_en=10 SHALL select tgt=1, then go to DEAD with the dead counter cleared.
REQ-018 In IDLE, on_en=11 SHALL keep the FSM in IDLE, hold gate=00 and set conflict_flag.
REQ-019 In DEAD, gate SHALL be 00 and the counter SHALL count DEAD_CYC cycles; at expiry, on_en[tgt]=1 with on_en[~tgt]=0 SHALL go to ON, otherwise to IDLE.
REQ-020 In ON, gate[tgt] SHALL be 1 and gate[~tgt] SHALL be 0; gate SHALL never equal 11 in any state.
REQ-021 In ON, when on_en[tgt] falls or on_en[~tgt] rises, the FSM SHALL go to IDLE, with gate low on the next edge.
REQ-022 In ON, the on counter SHALL be 23 bits or wider, saturating; at the MAX_ON_CYC-th ON cycle the FSM SHALL set timeout_flag[tgt] and go to HOLD.
REQ-023 In HOLD, gate SHALL be 00 and the FSM SHALL remain in HOLD until on_en[tgt]=0, then go to IDLE.
REQ-024 flt_s=1 in any state except FAULT SHALL force FAULT on the next edge, set fault_flag and drive gate=00; fault detection SHALL have priority over all other transitions.
REQ-025 The latency from a fault input edge to gate=00 SHALL be at most 3 sys_clk cycles.
REQ-026 In FAULT, gate SHALL be 00 and clr_fault=1 SHALL go to RSTDRV; clr_fault in any other state SHALL be ignored.
REQ-027 In RSTDRV, reset_drv SHALL be 11 for exactly RST_PULSE_CYC cycles, flt_s SHALL be ignored, and the FSM SHALL then go to WAITREL.
REQ-028 In WAITREL, flt_s=1 SHALL go to FAULT (fault_flag stays set); flt_s=0 with on_en=00 SHALL clear fault_flag and go to IDLE; otherwise the FSM SHALL wait.
REQ-029 timeout_flag and conflict_flag SHALL clear only on the clr_fault FAULT->RSTDRV transition or on reset.

Reset
REQ-030 Reset assertion SHALL asynchronously force the FSM to IDLE, clear all counters and synchronizers, and drive gate=00, reset_drv=00 and all flags to 0.
REQ-031 Reset deassertion mid-ON SHALL leave the block in IDLE, so any new request incurs a full DEAD_CYC delay.

Verification
REQ-032 on_en=01 held -> gate=01 exactly DEAD_CYC+1 cycles after the request edge; on_en->00 -> gate=00 on the next cycle.
REQ-033 In ON ch1, switch on_en 01->10 in one cycle -> gate 01->00 for at least DEAD_CYC cycles, then 10; gate is never 11.
REQ-034 on_en=11 from IDLE -> gate stays 00, conflict_flag=1.
REQ-035 With MAX_ON_CYC=100, hold on_en=10 -> gate[1] is high for 100 cycles, then timeout_flag=10 and gate stays 00 until on_en is released.
REQ-036 Pulse error_drv[0] while in ON -> gate=00 within 3 cycles, fault_flag=1; clr_fault -> reset_drv=11 for 500 cycles; fault clear with on_en=00 -> fault_flag=0 and the FSM returns to IDLE.
REQ-037 Assert sys_rst_n=0 mid-DEAD and mid-RSTDRV -> all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/igbt_gate_drive_ctrl.sv
// Two-channel IGBT gate sequencer: dead-time before every turn-on, mutually exclusive gates,
// max-on timeout, and a latched fault path with a driver-board reset pulse.
module igbt_gate_drive_ctrl #(
    parameter int DEAD_CYC      = 50,
    parameter int MAX_ON_CYC    = 5000000,
    parameter int RST_PULSE_CYC = 500
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] on_en,
    input  logic [1:0] fault_drv,
    input  logic [1:0] error_drv,
    input  logic       clr_fault,
    output logic [1:0] gate,
    output logic [1:0] reset_drv,
    output logic       fault_flag,
    output logic [1:0] timeout_flag,
    output logic       conflict_flag
);
    localparam int MAX_A     = (DEAD_CYC > RST_PULSE_CYC) ? DEAD_CYC : RST_PULSE_CYC;
    localparam int MAX_CNT   = (MAX_ON_CYC > MAX_A) ? MAX_ON_CYC : MAX_A;
    localparam int CNT_W_MIN = $clog2(MAX_CNT + 1);
    localparam int CNT_W     = (CNT_W_MIN > 23) ? CNT_W_MIN : 23;

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MAX_ON_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAD,
        S_ON,
        S_HOLD,
        S_FAULT,
        S_RSTDRV,
        S_WAITREL
    } state_t;

    state_t           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       sync1_q, sync2_q;
    logic [1:0]       gate_q, gate_d;
    logic [1:0]       reset_drv_q, reset_drv_d;
    logic [1:0]       timeout_q, timeout_d;
    logic             fault_q, fault_d;
    logic             conflict_q, conflict_d;
    logic             flt_s;
    logic [1:0]       want;

    assign flt_s   = |sync2_q;
    // The only on_en pattern that keeps the selected channel conducting.
    assign want    = tgt_q ? 2'b10 : 2'b01;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_inc;
        timeout_d  = timeout_q;
        conflict_d = conflict_q;

        if (flt_s && state_q != S_FAULT && state_q != S_RSTDRV) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    case (on_en)
                        2'b01: begin
                            tgt_d   = 1'b0;
                            state_d = S_DEAD;
                        end
                        2'b10: begin
                            tgt_d   = 1'b1;
                            state_d = S_DEAD;
                        end
                        2'b11: conflict_d = 1'b1;
                        default: ;
                    endcase
                end
                S_DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        cnt_d   = '0;
                        state_d = (on_en == want) ? S_ON : S_IDLE;
                    end
                end
                S_ON: begin
                    if (cnt_q == ON_LAST) begin
                        timeout_d[tgt_q] = 1'b1;
                        state_d          = S_HOLD;
                    end else if (on_en != want) begin
                        state_d = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!on_en[tgt_q]) state_d = S_IDLE;
                end
                S_FAULT: begin
                    cnt_d = '0;
                    if (clr_fault) begin
                        state_d    = S_RSTDRV;
                        timeout_d  = 2'b00;
                        conflict_d = 1'b0;
                    end
                end
                S_RSTDRV: begin
                    if (cnt_q == RST_LAST) state_d = S_WAITREL;
                end
                S_WAITREL: begin
                    if (on_en == 2'b00) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register together with it.
        gate_d      = (state_d == S_ON) ? (tgt_d ? 2'b10 : 2'b01) : 2'b00;
        reset_drv_d = (state_d == S_RSTDRV) ? 2'b11 : 2'b00;
        fault_d     = (state_d == S_FAULT) || (state_d == S_RSTDRV) || (state_d == S_WAITREL);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= S_IDLE;
            tgt_q       <= 1'b0;
            cnt_q       <= '0;
            gate_q      <= 2'b00;
            reset_drv_q <= 2'b00;
            timeout_q   <= 2'b00;
            fault_q     <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            sync1_q     <= {error_drv, fault_drv};
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            gate_q      <= gate_d;
            reset_drv_q <= reset_drv_d;
            timeout_q   <= timeout_d;
            fault_q     <= fault_d;
            conflict_q  <= conflict_d;
        end
    end

    assign gate          = gate_q;
    assign reset_drv     = reset_drv_q;
    assign fault_flag    = fault_q;
    assign timeout_flag  = timeout_q;
    assign conflict_flag = conflict_q;
endmodule

// File: tb/tb_igbt_gate_drive_ctrl.sv
// Bench for igbt_gate_drive_ctrl: directed vector table, corner-case sequences,
// then randomized stimulus against a deadline-based reference model.
`timescale 1ns/1ps
module tb_igbt_gate_drive_ctrl;
    localparam int DEAD  = 12;
    localparam int MAXON = 100;
    localparam int RSTP  = 500;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] on_en = 2'b00;
    logic [1:0] fault_drv = 2'b00;
    logic [1:0] error_drv = 2'b00;
    logic       clr = 1'b0;
    logic [1:0] gate, reset_drv, timeout_flag;
    logic       fault_flag, conflict_flag;

    igbt_gate_drive_ctrl #(
        .DEAD_CYC     (DEAD),
        .MAX_ON_CYC   (MAXON),
        .RST_PULSE_CYC(RSTP)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .on_en        (on_en),
        .fault_drv    (fault_drv),
        .error_drv    (error_drv),
        .clr_fault    (clr),
        .gate         (gate),
        .reset_drv    (reset_drv),
        .fault_flag   (fault_flag),
        .timeout_flag (timeout_flag),
        .conflict_flag(conflict_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    longint unsigned edge_no = 0;

    // Reference model: phases with absolute expiry times rather than counters.
    localparam int P_IDLE = 0, P_DEAD = 1, P_ON = 2, P_HOLD = 3, P_FAULT = 4, P_RST = 5, P_WAIT = 6;
    int              m_ph;
    int              m_tgt;
    longint unsigned m_until;
    bit [1:0]        m_to;
    bit              m_cf;
    bit              m_h0, m_h1;

    task automatic model_reset();
        m_ph = P_IDLE; m_tgt = 0; m_until = 0; m_to = 2'b00; m_cf = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0;
    endtask

    task automatic model_edge();
        bit       fs;
        bit [1:0] keep;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fs   = m_h1;
        m_h1 = m_h0;
        m_h0 = |{fault_drv, error_drv};
        keep = (m_tgt == 1) ? 2'b10 : 2'b01;
        if (fs && m_ph != P_FAULT && m_ph != P_RST) begin
            m_ph = P_FAULT;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    if (on_en == 2'b01 || on_en == 2'b10) begin
                        m_tgt = int'(on_en[1]); m_ph = P_DEAD; m_until = edge_no + DEAD;
                    end else if (on_en == 2'b11) m_cf = 1'b1;
                end
                P_DEAD: if (edge_no == m_until) begin
                    if (on_en == keep) begin m_ph = P_ON; m_until = edge_no + MAXON; end
                    else m_ph = P_IDLE;
                end
                P_ON: begin
                    if (edge_no == m_until) begin m_to[m_tgt] = 1'b1; m_ph = P_HOLD; end
                    else if (on_en != keep) m_ph = P_IDLE;
                end
                P_HOLD:  if (!on_en[m_tgt]) m_ph = P_IDLE;
                P_FAULT: if (clr) begin m_ph = P_RST; m_until = edge_no + RSTP; m_to = 2'b00; m_cf = 1'b0; end
                P_RST:   if (edge_no == m_until) m_ph = P_WAIT;
                P_WAIT:  if (on_en == 2'b00) m_ph = P_IDLE;
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [1:0] g;
        g = (m_ph == P_ON) ? ((m_tgt == 1) ? 2'b10 : 2'b01) : 2'b00;
        return {g, (m_ph == P_RST) ? 2'b11 : 2'b00,
                (m_ph == P_FAULT || m_ph == P_RST || m_ph == P_WAIT), m_to, m_cf};
    endfunction

    function automatic logic [7:0] dut_out();
        return {gate, reset_drv, fault_flag, timeout_flag, conflict_flag};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_no);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        check("gate_never_11", (gate === 2'b11), 0);
    endtask

    task automatic wait_gate(input logic [1:0] want, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (gate !== want && n < limit);
    endtask

    typedef struct {
        string      name;
        logic [1:0] on;
        logic [1:0] flt;
        logic [1:0] err;
        logic       cl;
        int         cyc;
        logic [7:0] exp;   // {gate, reset_drv, fault_flag, timeout_flag, conflict_flag}
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [1:0] o, input logic [1:0] f,
                                input logic [1:0] e, input logic c, input int n,
                                input logic [1:0] g, input logic [1:0] rd, input logic ff,
                                input logic [1:0] to, input logic cf);
        vec_t v;
        v.name = nm; v.on = o; v.flt = f; v.err = e; v.cl = c; v.cyc = n;
        v.exp = {g, rd, ff, to, cf};
        return v;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   n, zeros, rdn, seg_left;
        int   fpulse;

        model_reset();
        repeat (3) step();
        check("reset_state", dut_out(), 8'h00);
        rst_n = 1'b1;

        //                 name            on     flt    err   clr  cyc   gate   rd     ff  to     cf
        tbl.push_back(mk("idle",          2'b00, 2'b00, 2'b00, 0,   3,   2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("clr_in_idle",   2'b00, 2'b00, 2'b00, 1,   1,   2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("ch1_dead",      2'b01, 2'b00, 2'b00, 0,   DEAD, 2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("ch1_on",        2'b01, 2'b00, 2'b00, 0,   1,   2'b01, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("ch1_release",   2'b00, 2'b00, 2'b00, 0,   1,   2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("ch2_dead",      2'b10, 2'b00, 2'b00, 0,   DEAD, 2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("ch2_on",        2'b10, 2'b00, 2'b00, 0,   1,   2'b10, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("ch2_on_last",   2'b10, 2'b00, 2'b00, 0,   MAXON-1, 2'b10, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("ch2_timeout",   2'b10, 2'b00, 2'b00, 0,   1,   2'b00, 2'b00, 0, 2'b10, 0));
        tbl.push_back(mk("hold",          2'b10, 2'b00, 2'b00, 0,   5,   2'b00, 2'b00, 0, 2'b10, 0));
        tbl.push_back(mk("hold_release",  2'b00, 2'b00, 2'b00, 0,   1,   2'b00, 2'b00, 0, 2'b10, 0));
        tbl.push_back(mk("conflict",      2'b11, 2'b00, 2'b00, 0,   2,   2'b00, 2'b00, 0, 2'b10, 1));
        tbl.push_back(mk("err_sync",      2'b00, 2'b00, 2'b01, 0,   2,   2'b00, 2'b00, 0, 2'b10, 1));
        tbl.push_back(mk("err_fault",     2'b00, 2'b00, 2'b01, 0,   1,   2'b00, 2'b00, 1, 2'b10, 1));
        tbl.push_back(mk("fault_latched", 2'b00, 2'b00, 2'b00, 0,   4,   2'b00, 2'b00, 1, 2'b10, 1));
        tbl.push_back(mk("clr_rstdrv",    2'b00, 2'b00, 2'b00, 1,   1,   2'b00, 2'b11, 1, 2'b00, 0));
        tbl.push_back(mk("rstdrv_last",   2'b00, 2'b00, 2'b00, 0,   RSTP-1, 2'b00, 2'b11, 1, 2'b00, 0));
        tbl.push_back(mk("rstdrv_end",    2'b00, 2'b00, 2'b00, 0,   1,   2'b00, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk("waitrel_busy",  2'b01, 2'b00, 2'b00, 0,   3,   2'b00, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk("waitrel_done",  2'b00, 2'b00, 2'b00, 0,   1,   2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk("fltdrv_fault",  2'b00, 2'b10, 2'b00, 0,   3,   2'b00, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk("fltdrv_clr",    2'b00, 2'b00, 2'b00, 1,   1,   2'b00, 2'b11, 1, 2'b00, 0));
        tbl.push_back(mk("fltdrv_wait",   2'b00, 2'b00, 2'b00, 0,   RSTP, 2'b00, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk("fltdrv_idle",   2'b00, 2'b00, 2'b00, 0,   1,   2'b00, 2'b00, 0, 2'b00, 0));

        foreach (tbl[i]) begin
            on_en = tbl[i].on; fault_drv = tbl[i].flt; error_drv = tbl[i].err; clr = tbl[i].cl;
            repeat (tbl[i].cyc) step();
            check(tbl[i].name, dut_out(), tbl[i].exp);
            $display("vec %0d %s: on=%b cyc=%0d out=%h", i, tbl[i].name, tbl[i].on, tbl[i].cyc, dut_out());
        end
        on_en = 2'b00; fault_drv = 2'b00; error_drv = 2'b00; clr = 1'b0;

        // Direct handover ch1 -> ch2 must pass through a full dead time.
        on_en = 2'b01;
        wait_gate(2'b01, 100, n);
        check("h1_turn_on_delay", n, DEAD + 1);
        on_en = 2'b10;
        wait_gate(2'b10, 200, n);
        zeros = n - 1;
        check("h1_gap_ge_dead", (zeros >= DEAD), 1);
        check("h1_gate_ch2", gate, 2'b10);
        $display("seq handover: gap=%0d cycles", zeros);

        // Fault latency, then driver-reset pulse width and release.
        error_drv = 2'b01;
        step();
        error_drv = 2'b00;
        n = 1;
        while (gate !== 2'b00 && n < 10) begin step(); n++; end
        check("h2_fault_latency_le3", (n <= 3), 1);
        check("h2_fault_flag", fault_flag, 1'b1);
        on_en = 2'b00;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        rdn = 0;
        while (reset_drv === 2'b11 && rdn < 600) begin rdn++; step(); end
        check("h2_rstdrv_width", rdn, RSTP);
        check("h2_flag_in_waitrel", fault_flag, 1'b1);
        step();
        check("h2_flag_cleared", fault_flag, 1'b0);
        $display("seq fault: latency=%0d rstdrv=%0d", n, rdn);

        // Asynchronous reset mid-DEAD.
        on_en = 2'b01;
        repeat (5) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("h3_async_rst_dead", dut_out(), 8'h00);
        on_en = 2'b00;
        step();
        rst_n = 1'b1;

        // Asynchronous reset mid-RSTDRV.
        error_drv = 2'b10;
        repeat (4) step();
        error_drv = 2'b00;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (50) step();
        check("h3_in_rstdrv", reset_drv, 2'b11);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("h3_async_rst_rstdrv", dut_out(), 8'h00);
        step();
        rst_n = 1'b1;

        // Reset during ON: the next request pays the full dead time again.
        on_en = 2'b01;
        wait_gate(2'b01, 100, n);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("h4_async_rst_on", gate, 2'b00);
        step();
        rst_n = 1'b1;
        wait_gate(2'b01, 100, n);
        check("h4_redo_dead", n, DEAD + 1);
        $display("seq reset-in-on: turn-on after %0d cycles", n);
        on_en = 2'b00;
        step();

        // Randomized run against the model.
        seg_left = 0;
        fpulse = 0;
        for (int c = 0; c < 8000; c++) begin
            if (seg_left == 0) begin
                case ($urandom_range(0, 6))
                    0, 1:    on_en = 2'b00;
                    2, 3:    on_en = 2'b01;
                    4, 5:    on_en = 2'b10;
                    default: on_en = 2'b11;
                endcase
                seg_left = $urandom_range(1, 250);
                $display("rand seg @%0d: on=%b len=%0d out=%h", c, on_en, seg_left, dut_out());
            end
            seg_left--;
            if (fpulse > 0) begin
                fpulse--;
            end else begin
                fault_drv = 2'b00;
                error_drv = 2'b00;
                if ($urandom_range(0, 399) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       fault_drv = 2'b01;
                        1:       fault_drv = 2'b10;
                        2:       error_drv = 2'b01;
                        default: error_drv = 2'b10;
                    endcase
                    fpulse = $urandom_range(0, 2);
                end
            end
            clr = ($urandom_range(0, 29) == 0);
            step();
            check("rand_vs_model", dut_out(), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
